// File: rtl/mips_bus_arb.sv
// Shares one memory port between the MIPS I code and data buses: data access first, then fetch, then one run clock.
// Optional access timeout enabled by defining MIPS_BUS_ARB_TIMEOUT_EN (counter width TO_BITS).
module mips_bus_arb #(
    parameter int TO_BITS = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc,
    output logic [31:0] o_op,
    input  logic [31:0] i_da,
    input  logic [3:0]  i_we,
    input  logic [31:0] i_do,
    input  logic        i_re,
    output logic [31:0] o_di,
    output logic        o_run,
    output logic [31:0] o_ma,
    output logic [3:0]  o_mwe,
    output logic [31:0] o_mwd,
    output logic        o_mre,
    output logic        o_mreq,
    input  logic        i_mack,
    input  logic [31:0] i_mrd,
    output logic        o_err
);

    localparam logic [1:0] ST_ARB  = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_INSN = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    if (TO_BITS < 1) begin : g_bad_to_bits
        $error("mips_bus_arb: TO_BITS must be at least 1");
    end

    logic [1:0]  r_state;
    logic [31:0] r_op;
    logic [31:0] r_di;
    logic        w_data_req;
    logic        w_abort;
    logic        w_done;

    assign w_data_req = i_re | (|i_we);
    assign o_mreq     = (r_state == ST_DATA) || (r_state == ST_INSN);
    assign o_run      = (r_state == ST_RUN);
    assign o_op       = r_op;
    assign o_di       = r_di;
    assign w_done     = i_mack | w_abort;

`ifdef MIPS_BUS_ARB_TIMEOUT_EN
    logic [TO_BITS-1:0] r_to_cnt;
    logic [TO_BITS-1:0] w_to_inc;
    logic               r_err;

    // Abort on the wait clock whose increment would bring the counter to all-ones.
    assign w_to_inc = r_to_cnt + TO_BITS'(1);
    assign w_abort  = o_mreq && !i_mack && (&w_to_inc);
    assign o_err    = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (o_mreq && !i_mack && !w_abort) begin
                r_to_cnt <= w_to_inc;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_abort = 1'b0;
    assign o_err   = 1'b0;
`endif

    always_comb begin
        o_ma  = '0;
        o_mwe = '0;
        o_mwd = '0;
        o_mre = 1'b0;
        case (r_state)
            ST_DATA: begin
                o_ma  = i_da;
                o_mwe = i_we;
                o_mwd = i_do;
                o_mre = i_re;
            end
            ST_INSN: begin
                o_ma  = i_pc;
                o_mre = 1'b1;
            end
            default: ;
        endcase
    end

    // An aborted access still advances the sequence but captures zero (NOP for a fetch).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_ARB;
            r_op    <= '0;
            r_di    <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    r_state <= w_data_req ? ST_DATA : ST_INSN;
                end
                ST_DATA: begin
                    if (w_done) begin
                        r_di    <= (i_mack && i_re) ? i_mrd : '0;
                        r_state <= ST_INSN;
                    end
                end
                ST_INSN: begin
                    if (w_done) begin
                        r_op    <= i_mack ? i_mrd : '0;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arb.sv
// Directed bench for mips_bus_arb with a small wait-state memory slave model.
module tb_mips_bus_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc, da, dout, op, di, ma, mwd, mrd;
    logic [3:0]  we, mwe;
    logic        re, run, mre, mreq, mack, err;

    int n_vec = 0;
    int n_err = 0;

    // Slave model: acks after wait_states clocks of request when enabled.
    int   wait_states = 0;
    int   wcnt = 0;
    logic mack_en = 1'b1;

    always #5 clk = ~clk;

    mips_bus_arb #(.TO_BITS(3)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_pc   (pc),
        .o_op   (op),
        .i_da   (da),
        .i_we   (we),
        .i_do   (dout),
        .i_re   (re),
        .o_di   (di),
        .o_run  (run),
        .o_ma   (ma),
        .o_mwe  (mwe),
        .o_mwd  (mwd),
        .o_mre  (mre),
        .o_mreq (mreq),
        .i_mack (mack),
        .i_mrd  (mrd),
        .o_err  (err)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        case (addr)
            32'h0000_0100: return 32'h2402_0005;
            32'h0000_0104: return 32'h0043_1821;
            32'h0000_0200: return 32'hDEAD_BEEF;
            default:       return 32'h5A5A_0000;
        endcase
    endfunction

    assign mack = mreq && mack_en && (wcnt >= wait_states);
    assign mrd  = mem_rd(ma);

    always @(posedge clk) begin
        if (mreq && !mack) wcnt <= wcnt + 1;
        else               wcnt <= 0;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc = 32'h100; da = '0; we = '0; dout = '0; re = 1'b0;
        repeat (2) step();
        n_vec++;
        if ({mreq, run, mre, err} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctl: got mreq/run/mre/err=%b want 0000", {mreq, run, mre, err});
        end
        n_vec++;
        if ({op, di, ma, mwd, mwe} !== 100'd0) begin
            n_err++; $display("FAIL reset_data: got op=%h di=%h ma=%h mwd=%h mwe=%b want all 0", op, di, ma, mwd, mwe);
        end
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_fetch();
        pc = 32'h100;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({mreq, run} !== 2'b00) begin
                n_err++; $display("FAIL fetch_arb[%0d]: got mreq/run=%b want 00", k, {mreq, run});
            end
            step();
            n_vec++;
            if ({mreq, run, mre, mwe, ma} !== {3'b101, 4'b0000, 32'h100}) begin
                n_err++; $display("FAIL fetch_insn[%0d]: got mreq=%b run=%b mre=%b mwe=%b ma=%h want 1 0 1 0000 00000100", k, mreq, run, mre, mwe, ma);
            end
            step();
            n_vec++;
            if ({mreq, run, op} !== {2'b01, 32'h2402_0005}) begin
                n_err++; $display("FAIL fetch_run[%0d]: got mreq=%b run=%b op=%h want 0 1 24020005", k, mreq, run, op);
            end
            $display("fetch: pc=%h op=%h", pc, op);
            step();
        end
    endtask

    task automatic test_load();
        re = 1'b1; da = 32'h200; pc = 32'h104;
        n_vec++;
        if ({mreq, run} !== 2'b00) begin
            n_err++; $display("FAIL load_arb: got mreq/run=%b want 00", {mreq, run});
        end
        step();
        n_vec++;
        if ({mreq, mre, mwe, ma} !== {2'b11, 4'b0000, 32'h200}) begin
            n_err++; $display("FAIL load_data: got mreq=%b mre=%b mwe=%b ma=%h want 1 1 0000 00000200", mreq, mre, mwe, ma);
        end
        step();
        n_vec++;
        if ({mreq, mre, ma} !== {2'b11, 32'h104}) begin
            n_err++; $display("FAIL load_insn: got mreq=%b mre=%b ma=%h want 1 1 00000104", mreq, mre, ma);
        end
        step();
        n_vec++;
        if ({run, di, op} !== {1'b1, 32'hDEAD_BEEF, 32'h0043_1821}) begin
            n_err++; $display("FAIL load_run: got run=%b di=%h op=%h want 1 deadbeef 00431821", run, di, op);
        end
        $display("load: da=%h di=%h", da, di);
        step();
        re = 1'b0;
    endtask

    task automatic test_store();
        we = 4'b0011; dout = 32'h1234; da = 32'h300; pc = 32'h100; wait_states = 2;
        step();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({mreq, run, mre, mwe, mwd, ma, mack} !== {3'b100, 4'b0011, 32'h1234, 32'h300, (k == 2)}) begin
                n_err++; $display("FAIL store_hold[%0d]: got mreq=%b run=%b mre=%b mwe=%b mwd=%h ma=%h mack=%b want 1 0 0 0011 00001234 00000300 %b",
                                  k, mreq, run, mre, mwe, mwd, ma, mack, (k == 2));
            end
            if (k == 2) wait_states = 0;
            step();
        end
        n_vec++;
        if ({mreq, run, ma} !== {2'b10, 32'h100}) begin
            n_err++; $display("FAIL store_insn: got mreq=%b run=%b ma=%h want 1 0 00000100", mreq, run, ma);
        end
        step();
        n_vec++;
        if ({run, di} !== {1'b1, 32'h0}) begin
            n_err++; $display("FAIL store_run: got run=%b di=%h want 1 00000000", run, di);
        end
        $display("store: da=%h we=%b wd=%h", da, we, dout);
        step();
        we = '0;
    endtask

    task automatic test_reset_mid();
        re = 1'b1; da = 32'h200; pc = 32'h104; mack_en = 1'b0;
        step();
        n_vec++;
        if ({mreq, op} !== {1'b1, 32'h2402_0005}) begin
            n_err++; $display("FAIL rstmid_pre: got mreq=%b op=%h want 1 24020005", mreq, op);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({mreq, run, op, di} !== {2'b00, 64'd0}) begin
            n_err++; $display("FAIL rstmid_async: got mreq=%b run=%b op=%h di=%h want 0 0 0 0", mreq, run, op, di);
        end
        step();
        rst_n = 1'b1; re = 1'b0; mack_en = 1'b1; pc = 32'h100;
        n_vec++;
        if ({mreq, run} !== 2'b00) begin
            n_err++; $display("FAIL rstmid_arb: got mreq/run=%b want 00", {mreq, run});
        end
        step();
        n_vec++;
        if ({mreq, ma} !== {1'b1, 32'h100}) begin
            n_err++; $display("FAIL rstmid_insn: got mreq=%b ma=%h want 1 00000100", mreq, ma);
        end
        step();
        n_vec++;
        if ({run, op} !== {1'b1, 32'h2402_0005}) begin
            n_err++; $display("FAIL rstmid_run: got run=%b op=%h want 1 24020005", run, op);
        end
        $display("reset_mid: restarted, op=%h", op);
        step();
    endtask

`ifdef MIPS_BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        pc = 32'h100; mack_en = 1'b0;
        step();
        for (int k = 0; k < 7; k++) begin
            n_vec++;
            if ({mreq, run, err} !== 3'b100) begin
                n_err++; $display("FAIL to_wait[%0d]: got mreq/run/err=%b want 100", k, {mreq, run, err});
            end
            step();
        end
        n_vec++;
        if ({mreq, run, err, op} !== {3'b011, 32'h0}) begin
            n_err++; $display("FAIL to_abort: got mreq=%b run=%b err=%b op=%h want 0 1 1 00000000", mreq, run, err, op);
        end
        mack_en = 1'b1;
        step();
        step();
        step();
        n_vec++;
        if ({run, err, op} !== {2'b11, 32'h2402_0005}) begin
            n_err++; $display("FAIL to_recover: got run=%b err=%b op=%h want 1 1 24020005", run, err, op);
        end
        $display("timeout: aborted fetch, err=%b", err);
        step();
    endtask
`else
    task automatic test_timeout();
        logic bad;
        bad = 1'b0;
        pc = 32'h100; mack_en = 1'b0;
        step();
        for (int k = 0; k < 1000; k++) begin
            if ({mreq, run, err} !== 3'b100) bad = 1'b1;
            step();
        end
        n_vec++;
        if (bad !== 1'b0) begin
            n_err++; $display("FAIL stall_hold: got a clock with mreq/run/err != 100 want 100 throughout");
        end
        n_vec++;
        if ({mreq, ma, err} !== {1'b1, 32'h100, 1'b0}) begin
            n_err++; $display("FAIL stall_end: got mreq=%b ma=%h err=%b want 1 00000100 0", mreq, ma, err);
        end
        mack_en = 1'b1;
        step();
        n_vec++;
        if ({run, err, op} !== {2'b10, 32'h2402_0005}) begin
            n_err++; $display("FAIL stall_done: got run=%b err=%b op=%h want 1 0 24020005", run, err, op);
        end
        $display("stall: 1000 clocks held, op=%h", op);
        step();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_bus_arb.md
# mips_bus_arb

Sequencer that shares one unified memory port between the MIPS I core's code bus (PC/op) and data bus (DA/we/DO/re/DI). Each core cycle it serves the data access first, then the instruction fetch. While it works it holds the core frozen through a clock-enable output, then releases it for exactly one clock with op and DI valid. It sits between mips_core and the external memory/bus slave.

## Interface
- TO_BITS, 8, width of the access-timeout counter (used only with MIPS_BUS_ARB_TIMEOUT_EN)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous active-low reset
- PC  in  32  core fetch address
- op  out  32  fetched instruction to core
- DA  in  32  core data address, word aligned
- we  in  4  core byte write enables
- DO  in  32  core write data
- re  in  1  core read request
- DI  out  32  read data to core
- run  out  1  core clock enable; core registers advance only when 1
- MA  out  32  memory address
- MWE  out  4  memory byte write enables
- MWD  out  32  memory write data
- MRE  out  1  memory read strobe
- MREQ  out  1  memory request
- MACK  in  1  memory acknowledge, may be combinational from MREQ
- MRD  in  32  memory read data, valid in MACK cycle
- err  out  1  sticky timeout flag

## Operation
- States: ARB, DATA, INSN, RUN.
- ARB: run=0, MREQ=0. Data request = re | (we != 0). Go to DATA if set, else INSN.
- DATA: MREQ=1, MA=DA, MWE=we, MWD=DO, MRE=re. At the edge with MACK=1: if re, capture MRD into the DI register, else clear it to 0. Then go to INSN.
- INSN: MREQ=1, MA=PC, MWE=0, MWD=0, MRE=1. At the edge with MACK=1: capture MRD into the op register, then go to RUN.
- RUN: run=1, MREQ=0. op and DI are driven from their registers. Go to ARB.
- Outside DATA/INSN, MA, MWE, MWD and MRE are 0.
- Core inputs are sampled only in ARB/DATA/INSN. They are stable there because run=0.
- Data always wins over fetch. There is no starvation, since each core cycle carries at most one data access.
- Bus rule: MA, MWE, MWD and MRE stay stable while MREQ=1 until MACK is sampled.
- DATA→INSN keeps MREQ high with a new address. The slave must treat every acked edge as one completed transfer.
- MACK while MREQ=0 is ignored.

## Timing
- Reset (asynchronous, active-low) forces:
  - state=ARB, run=0, MREQ=0, MA/MWE/MWD/MRE=0
  - op=0 (NOP), DI=0, err=0, timeout counter=0
- Reset mid-transfer drops MREQ immediately. No partial capture survives.
- First cycle after reset release: ARB.
- With a zero-wait slave (MACK=1 in the request cycle):
  - no data access: 3 clocks per core cycle (ARB, INSN, RUN)
  - with a data access: 4 clocks (ARB, DATA, INSN, RUN)
- Each clock with MREQ=1 and MACK=0 adds one clock.
- run is high for exactly one clock per core cycle, registered from state.
- op and DI change only at the edge leaving INSN or DATA, so they are constant throughout RUN.

## Configuration
- MIPS_BUS_ARB_TIMEOUT_EN defined:
  - A TO_BITS-wide counter clears on entry to DATA/INSN and increments each clock with MREQ=1 and MACK=0.
  - When it reaches all-ones without an ack, the access is aborted and the state advances as if acked, with captured data forced to 0. A fetch therefore yields NOP; a load yields 0; a store is dropped.
  - err is set and stays set until reset.
- Undefined: no counter, waits indefinitely for MACK, err tied 0.

## Test plan
- Zero-wait slave, PC=0x100, no data request, memory[0x100]=0x24020005 → ARB,INSN,RUN repeating; run high 1 of 3 clocks; op=0x24020005 during RUN.
- Load: re=1, we=0, DA=0x200, mem[0x200]=0xDEADBEEF → MA=0x200 MRE=1 in DATA, then MA=PC in INSN; DI=0xDEADBEEF in RUN; 4 clocks per core cycle.
- Store: we=4'b0011, DO=0x1234, DA=0x300, two wait states → MWE=0011, MWD=0x1234 held stable for 3 clocks until MACK; DI=0 in RUN; run low throughout.
- Assert reset low while in DATA with MACK=0 → MREQ=0, op=0, DI=0, run=0 before the next edge; after release the sequence restarts in ARB.
- With MIPS_BUS_ARB_TIMEOUT_EN, TO_BITS=3, MACK stuck 0 on fetch → abort after 7 wait clocks; op=0 in RUN; err=1 and stays 1.
- Without the macro, MACK stuck 0 for 1000 clocks → MREQ stays 1, run stays 0, err=0; the first MACK completes normally.
